// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the UART-to-ALU frame controller: ALU opcodes,
// controller states and elaboration-time parameter checks.
package alu_uart_ctrl_pkg;

    localparam logic [5:0] OP_SLL  = 6'h00;
    localparam logic [5:0] OP_SRL  = 6'h02;
    localparam logic [5:0] OP_SRA  = 6'h03;
    localparam logic [5:0] OP_ADD  = 6'h20;
    localparam logic [5:0] OP_SUB  = 6'h22;
    localparam logic [5:0] OP_AND  = 6'h24;
    localparam logic [5:0] OP_OR   = 6'h25;
    localparam logic [5:0] OP_XOR  = 6'h26;
    localparam logic [5:0] OP_NOR  = 6'h27;
    localparam logic [5:0] OP_SLT  = 6'h2A;
    // Parked opcode driven while no valid frame is held
    localparam logic [5:0] IDLE_OP = 6'h3F;

    localparam int unsigned SHAMT_W = 5;

    typedef enum logic [2:0] {
        StIdle,
        StGetA,
        StGetB,
        StGetSh,
        StCapture,
        StSend,
        StWaitTx
    } state_e;

    function automatic bit nb_data_ok(input int unsigned nb_data);
        return (nb_data != 0) && (nb_data % 8 == 0);
    endfunction

    function automatic int unsigned bytes_per_word(input int unsigned nb_data);
        return nb_data / 8;
    endfunction

endpackage

// File: rtl/alu_uart_ctrl_if.sv
// Bundle of UART byte handshakes and ALU operand/result lines seen by the controller.
interface alu_uart_ctrl_if #(
    parameter int unsigned NB_OP   = 6,
    parameter int unsigned NB_DATA = 8
);
    logic               i_rx_done;
    logic [7:0]         i_rx_data;
    logic               i_tx_done;
    logic               o_tx_start;
    logic [7:0]         o_tx_data;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_alu_data_A;
    logic [NB_DATA-1:0] o_alu_data_B;
    logic [4:0]         o_alu_shamt;
    logic [NB_DATA-1:0] i_alu_result;
    logic               o_busy;
    logic               o_error;

    // Controller side
    modport master (
        input  i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        output o_tx_start, o_tx_data, o_alu_op, o_alu_data_A, o_alu_data_B, o_alu_shamt,
        output o_busy, o_error
    );

    // UART/ALU side
    modport slave (
        output i_rx_done, i_rx_data, i_tx_done, i_alu_result,
        input  o_tx_start, o_tx_data, o_alu_op, o_alu_data_A, o_alu_data_B, o_alu_shamt,
        input  o_busy, o_error
    );

endinterface

// File: rtl/alu_uart_ctrl_byte_timeout.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry once TIMEOUT_TICKS cycles have elapsed.
module alu_uart_ctrl_byte_timeout #(
    parameter int unsigned TIMEOUT_TICKS = 1_000_000
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_enable,
    input  logic i_clear,
    output logic o_expired
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_TICKS + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign o_expired = (cnt_q == CNT_W'(TIMEOUT_TICKS));

    // Saturates at expiry so the flag stays up until cleared
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_enable && !o_expired) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/alu_uart_ctrl.sv
// Frame controller: assembles OP/A/B/SHAMT from UART bytes, drives the ALU from
// holding registers, then returns the captured result LSB first over UART TX.
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int unsigned NB_OP         = 6,
    parameter int unsigned NB_DATA       = 8,
    parameter int unsigned TIMEOUT_TICKS = 1_000_000
) (
    input  logic            i_clk,
    input  logic            i_reset,
    alu_uart_ctrl_if.master bus
);

    if (!nb_data_ok(NB_DATA)) begin : g_bad_nb_data
        $fatal(1, "alu_uart_ctrl: NB_DATA must be a non-zero multiple of 8");
    end

    localparam int unsigned      BPW      = bytes_per_word(NB_DATA);
    localparam int unsigned      IDX_W    = $clog2(BPW) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BPW - 1);
    localparam logic [IDX_W-1:0] ALL_SENT = IDX_W'(BPW);
    localparam logic [NB_OP-1:0] IDLE_OP_W = NB_OP'(IDLE_OP);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [IDX_W-1:0]   tx_idx_q, tx_idx_d;
    logic [NB_OP-1:0]   op_q;
    logic [NB_DATA-1:0] a_q, b_q, result_q;
    logic [4:0]         sh_q;
    logic [7:0]         tx_data_q, tx_byte;

    logic in_get, expired;
    logic ld_op, ld_a, ld_b, ld_sh, ld_res, ld_tx, clr_op;
    logic tx_start, busy, error;

    assign in_get = (state_q == StGetA) || (state_q == StGetB) || (state_q == StGetSh);

    alu_uart_ctrl_byte_timeout #(
        .TIMEOUT_TICKS (TIMEOUT_TICKS)
    ) u_byte_timeout (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_enable  (in_get),
        .i_clear   (bus.i_rx_done || !in_get),
        .o_expired (expired)
    );

    always_comb begin
        state_d  = state_q;
        tx_idx_d = tx_idx_q;
        tx_byte  = tx_data_q;
        ld_op    = 1'b0;
        ld_a     = 1'b0;
        ld_b     = 1'b0;
        ld_sh    = 1'b0;
        ld_res   = 1'b0;
        ld_tx    = 1'b0;
        clr_op   = 1'b0;
        tx_start = 1'b0;
        error    = 1'b0;
        busy     = (state_q != StIdle);

        unique case (state_q)
            StIdle: begin
                if (bus.i_rx_done) begin
                    ld_op   = 1'b1;
                    state_d = StGetA;
                end
            end
            StGetA: begin
                if (bus.i_rx_done) begin
                    ld_a = 1'b1;
                    if (byte_idx_q == LAST_IDX) state_d = StGetB;
                end else if (expired) begin
                    error   = 1'b1;
                    clr_op  = 1'b1;
                    state_d = StIdle;
                end
            end
            StGetB: begin
                if (bus.i_rx_done) begin
                    ld_b = 1'b1;
                    if (byte_idx_q == LAST_IDX) state_d = StGetSh;
                end else if (expired) begin
                    error   = 1'b1;
                    clr_op  = 1'b1;
                    state_d = StIdle;
                end
            end
            StGetSh: begin
                if (bus.i_rx_done) begin
                    ld_sh   = 1'b1;
                    state_d = StCapture;
                end else if (expired) begin
                    error   = 1'b1;
                    clr_op  = 1'b1;
                    state_d = StIdle;
                end
            end
            StCapture: begin
                // Preload the first byte so o_tx_data is valid alongside the start pulse
                ld_res   = 1'b1;
                ld_tx    = 1'b1;
                tx_byte  = bus.i_alu_result[7:0];
                tx_idx_d = '0;
                state_d  = StSend;
            end
            StSend: begin
                tx_start = 1'b1;
                tx_idx_d = tx_idx_q + 1'b1;
                state_d  = StWaitTx;
            end
            StWaitTx: begin
                if (bus.i_tx_done) begin
                    if (tx_idx_q == ALL_SENT) begin
                        state_d = StIdle;
                    end else begin
                        ld_tx   = 1'b1;
                        tx_byte = result_q[8*tx_idx_q +: 8];
                        state_d = StSend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            byte_idx_d = '0;
        end else if (ld_a || ld_b) begin
            byte_idx_d = byte_idx_q + 1'b1;
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= StIdle;
            byte_idx_q <= '0;
            tx_idx_q   <= '0;
            op_q       <= IDLE_OP_W;
            a_q        <= '0;
            b_q        <= '0;
            sh_q       <= '0;
            result_q   <= '0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            tx_idx_q   <= tx_idx_d;
            if (ld_op) begin
                op_q <= bus.i_rx_data[NB_OP-1:0];
            end else if (clr_op) begin
                op_q <= IDLE_OP_W;
            end
            if (ld_a)   a_q[8*byte_idx_q +: 8] <= bus.i_rx_data;
            if (ld_b)   b_q[8*byte_idx_q +: 8] <= bus.i_rx_data;
            if (ld_sh)  sh_q      <= bus.i_rx_data[4:0];
            if (ld_res) result_q  <= bus.i_alu_result;
            if (ld_tx)  tx_data_q <= tx_byte;
        end
    end

    assign bus.o_tx_start   = tx_start;
    assign bus.o_tx_data    = tx_data_q;
    assign bus.o_alu_op     = op_q;
    assign bus.o_alu_data_A = a_q;
    assign bus.o_alu_data_B = b_q;
    assign bus.o_alu_shamt  = sh_q;
    assign bus.o_busy       = busy;
    assign bus.o_error      = error;

endmodule
